// File: rtl/pipe_mem_access_ctrl_if.sv
// Groups the MEM-stage pipeline inputs, data-memory handshake and MEM/WB outputs.
// slave: the access controller. master: the pipeline/memory side that drives it.
// Zero latency (wires only); backpressure is carried by the stall signal.
interface pipe_mem_access_ctrl_if #(
    parameter int DW = 32
);
    logic          mwreg;
    logic          mm2reg;
    logic          mwmem;
    logic [DW-1:0] malu;
    logic [DW-1:0] mb;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          err_clr;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mmo;
    logic          stall;
    logic          mwreg_o;
    logic          mm2reg_o;
    logic          bus_err;

    modport slave (
        input  mwreg, mm2reg, mwmem, malu, mb, mem_rdata, mem_ack, err_clr,
        output mem_req, mem_we, mem_addr, mem_wdata, mmo, stall, mwreg_o, mm2reg_o, bus_err
    );

    modport master (
        output mwreg, mm2reg, mwmem, malu, mb, mem_rdata, mem_ack, err_clr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mmo, stall, mwreg_o, mm2reg_o, bus_err
    );
endinterface

// File: rtl/pipe_mem_access_ctrl.sv
// MEM-stage sequencer: runs one req/ack memory access per load/store, times out after TIMEOUT cycles.
// Latency: ack in the k-th ACCESS cycle stalls the pipeline k+1 cycles; ALU ops pass with no delay.
// Backpressure: stall freezes upstream while an access is in flight; MEM/WB gets bubbles until done.
module pipe_mem_access_ctrl #(
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    pipe_mem_access_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] mmo_q, mmo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;
    logic          stall_c;
    logic          mwreg_c;
    logic          memop;

    // A load+store combination is treated as a store (mem_we follows mwmem).
    assign memop = bus.mm2reg | bus.mwmem;

    // Next-state, registered memory-bus values and combinational pipeline controls.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mmo_d       = mmo_q;
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q & ~bus.err_clr;
        stall_c     = 1'b0;
        mwreg_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall_c     = 1'b1;
                    mem_addr_d  = bus.malu;
                    mem_wdata_d = bus.mb;
                    mem_we_d    = bus.mwmem;
                    mem_req_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = ACCESS;
                end else begin
                    mwreg_c     = bus.mwreg;
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                // Ack is checked first so a completion on the last allowed cycle still succeeds.
                if (bus.mem_ack) begin
                    if (!mem_we_q) begin
                        mmo_d = bus.mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                mwreg_c = bus.mwreg;
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset aborts any access in flight.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mmo_q       <= '0;
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mmo_q       <= mmo_d;
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Pipeline controls are forced low while reset is asserted, independent of inputs.
    assign bus.stall     = clrn & stall_c;
    assign bus.mwreg_o   = clrn & mwreg_c;
    assign bus.mm2reg_o  = bus.mm2reg;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mmo       = mmo_q;
    assign bus.bus_err   = bus_err_q;

endmodule
